// File: rtl/sd_clk_gen_if.sv
// Host-side bundle for the SD clock generator: Clock Control register access plus card clock outputs.
// Optional macro SDCLK_PWR2_DIV_EN adds the div_mode select.
interface sd_clk_gen_if;
  // clk_ctrl_wr is a single-cycle strobe with no back-pressure: clk_ctrl_in is
  // taken on every ex_clk edge where clk_ctrl_wr=1, so the register is always ready.
  logic [15:0] clk_ctrl_in;
  logic        clk_ctrl_wr;
`ifdef SDCLK_PWR2_DIV_EN
  logic        div_mode;
`endif
  logic [15:0] clk_ctrl_out;
  logic        sd_clk;
  logic        sd_clk_rise;
  logic        sd_clk_fall;
  logic        sd_clk_running;
  logic [1:0]  fsm_state;

`ifdef SDCLK_PWR2_DIV_EN
  modport master (
    output clk_ctrl_in, clk_ctrl_wr, div_mode,
    input  clk_ctrl_out, sd_clk, sd_clk_rise, sd_clk_fall, sd_clk_running, fsm_state
  );
  modport slave (
    input  clk_ctrl_in, clk_ctrl_wr, div_mode,
    output clk_ctrl_out, sd_clk, sd_clk_rise, sd_clk_fall, sd_clk_running, fsm_state
  );
`else
  modport master (
    output clk_ctrl_in, clk_ctrl_wr,
    input  clk_ctrl_out, sd_clk, sd_clk_rise, sd_clk_fall, sd_clk_running, fsm_state
  );
  modport slave (
    input  clk_ctrl_in, clk_ctrl_wr,
    output clk_ctrl_out, sd_clk, sd_clk_rise, sd_clk_fall, sd_clk_running, fsm_state
  );
`endif
endinterface

// File: rtl/sd_clk_gen.sv
// SD card clock generator: Clock Control register, stable timer and glitch-free 2N divider.
// Optional macro SDCLK_PWR2_DIV_EN enables the power-of-two (SD v2) divisor mode.
module sd_clk_gen #(
  parameter int DIV_WIDTH     = 10,
  parameter int STABLE_CYCLES = 16
) (
  input  logic         ex_clk,
  input  logic         ex_resetn,
  sd_clk_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [7:0]           STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] ONE         = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_en;
  logic                  r_sd_en;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [7:0]            r_stab_cnt;
  logic                  r_stable;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [DIV_WIDTH-1:0]  r_n;
  logic                  r_sd_clk;
  logic                  r_rise;
  logic                  r_fall;
  logic                  w_stable;
  logic                  w_tc;
  logic                  w_active;
  logic [9:0]            w_wr_field;
  logic [9:0]            w_rd_div;
  logic [DIV_WIDTH-1:0]  w_field;
  logic [DIV_WIDTH-1:0]  w_n_m1;

  // Divisor field is {ctrl[7:6], ctrl[15:8]}; narrow builds simply drop the upper bits.
  assign w_wr_field = {bus.clk_ctrl_in[7:6], bus.clk_ctrl_in[15:8]};

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      r_en    <= 1'b0;
      r_sd_en <= 1'b0;
      r_div   <= '0;
    end else if (bus.clk_ctrl_wr) begin
      r_en    <= bus.clk_ctrl_in[0];
      r_sd_en <= bus.clk_ctrl_in[2];
      r_div   <= w_wr_field[DIV_WIDTH-1:0];
    end
  end

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      r_stab_cnt <= '0;
      r_stable   <= 1'b0;
    end else if (!r_en) begin
      r_stab_cnt <= '0;
      r_stable   <= 1'b0;
    end else if (!r_stable) begin
      r_stab_cnt <= r_stab_cnt + 8'd1;
      if (r_stab_cnt == STABLE_LAST) r_stable <= 1'b1;
    end
  end

  // Gating with r_en drops the flag in the very cycle the enable is seen low.
  assign w_stable = r_stable & r_en;

`ifdef SDCLK_PWR2_DIV_EN
  function automatic logic [7:0] msb_onehot(input logic [7:0] v);
    logic [7:0] res;
    res = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) res = 8'b1 << i;
    end
    return res;
  endfunction

  always_comb begin
    w_rd_div = 10'(r_div);
    w_field  = r_div;
    if (bus.div_mode) begin
      w_rd_div = {2'b00, msb_onehot(r_div[7:0])};
      w_field  = DIV_WIDTH'(w_rd_div);
    end
  end
`else
  always_comb begin
    w_rd_div = 10'(r_div);
    w_field  = r_div;
  end
`endif

  assign bus.clk_ctrl_out = {w_rd_div[7:0], w_rd_div[9:8], 3'b000, r_sd_en, w_stable, r_en};

  // Terminal count: N=0 behaves like N=1 so the clock toggles every cycle.
  assign w_n_m1   = (r_n == '0) ? '0 : (r_n - ONE);
  assign w_tc     = (r_div_cnt == w_n_m1);
  assign w_active = (r_state == ST_RUN) || ((r_state == ST_STOPPING) && r_sd_clk);

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      r_div_cnt <= '0;
      r_n       <= '0;
      r_sd_clk  <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else if (!w_active) begin
      r_div_cnt <= '0;
      r_n       <= w_field;
      r_sd_clk  <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else if (w_tc) begin
      // New divisor is only picked up here, so a phase is never cut short.
      r_div_cnt <= '0;
      r_n       <= w_field;
      r_sd_clk  <= ~r_sd_clk;
      r_rise    <= ~r_sd_clk;
      r_fall    <= r_sd_clk;
    end else begin
      r_div_cnt <= r_div_cnt + ONE;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end
  end

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) r_state <= ST_OFF;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:      if (r_sd_en && w_stable)    w_state_nxt = ST_RUN;
      ST_RUN:      if (!(r_sd_en && w_stable)) w_state_nxt = ST_STOPPING;
      ST_STOPPING: if (!r_sd_clk)              w_state_nxt = ST_OFF;
      default:                                 w_state_nxt = ST_OFF;
    endcase
  end

  assign bus.sd_clk         = r_sd_clk;
  assign bus.sd_clk_rise    = r_rise;
  assign bus.sd_clk_fall    = r_fall;
  assign bus.sd_clk_running = (r_state != ST_OFF);
  assign bus.fsm_state      = r_state;

endmodule

// File: tb/tb_sd_clk_gen.sv
// Self-checking bench for sd_clk_gen: directed register/stop/reset steps plus randomized divisors.
module tb_sd_clk_gen;
  localparam int DIV_WIDTH     = 10;
  localparam int STABLE_CYCLES = 16;

  logic ex_clk = 1'b0;
  logic ex_resetn;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_rise = 0;
  int   n_fall = 0;
  logic mon_prev = 1'b0;
  logic [15:0] exp_q[$];

  sd_clk_gen_if bus ();

  sd_clk_gen #(.DIV_WIDTH(DIV_WIDTH), .STABLE_CYCLES(STABLE_CYCLES)) dut (
    .ex_clk    (ex_clk),
    .ex_resetn (ex_resetn),
    .bus       (bus)
  );

  // clock / watchdog
  always #5 ex_clk = ~ex_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // strobe monitor: rise = first cycle high, fall = first cycle low after high
  always @(negedge ex_clk) begin
    if (!ex_resetn) begin
      mon_prev = 1'b0;
    end else begin
      check("rise_strobe", 32'(bus.sd_clk_rise), 32'(bus.sd_clk & ~mon_prev));
      check("fall_strobe", 32'(bus.sd_clk_fall), 32'(~bus.sd_clk & mon_prev));
      if (!bus.sd_clk_running)
        check("off_quiet", 32'({bus.sd_clk, bus.sd_clk_rise, bus.sd_clk_fall}), 32'd0);
      if (bus.sd_clk_rise) n_rise++;
      if (bus.sd_clk_fall) n_fall++;
      mon_prev = bus.sd_clk;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge ex_clk);
    #1;
  endtask

  task automatic write_reg(input logic [15:0] v);
    bus.clk_ctrl_in = v;
    bus.clk_ctrl_wr = 1'b1;
    tick();
    bus.clk_ctrl_wr = 1'b0;
  endtask

  task automatic wait_rise(input int limit);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (bus.sd_clk_rise !== 1'b1 && c < limit);
    check("rise_seen", 32'(bus.sd_clk_rise), 32'd1);
  endtask

  task automatic wait_stable();
    int c;
    c = 0;
    while (bus.clk_ctrl_out[1] !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    check("stable_seen", 32'(bus.clk_ctrl_out[1]), 32'd1);
  endtask

  // Called at a rise sample; ends at the next rise sample.
  task automatic measure(input int h_exp, input string tag);
    int hi;
    int lo;
    exp_q.push_back(16'(h_exp));
    exp_q.push_back(16'(h_exp));
    hi = 1;
    lo = 0;
    tick();
    while (bus.sd_clk === 1'b1 && hi < 2000) begin hi++; tick(); end
    while (bus.sd_clk === 1'b0 && lo < 2000) begin lo++; tick(); end
    check({tag, "_high"}, 32'(hi), 32'(exp_q.pop_front()));
    check({tag, "_low"},  32'(lo), 32'(exp_q.pop_front()));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"},    32'(bus.clk_ctrl_out),   32'd0);
    check({tag, "_sdclk"},   32'(bus.sd_clk),         32'd0);
    check({tag, "_rise"},    32'(bus.sd_clk_rise),    32'd0);
    check({tag, "_fall"},    32'(bus.sd_clk_fall),    32'd0);
    check({tag, "_running"}, 32'(bus.sd_clk_running), 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    int c;
    int hi;
    int lo;
    int r0;
    int f0;
    int n;

    bus.clk_ctrl_in = 16'h0000;
    bus.clk_ctrl_wr = 1'b0;
`ifdef SDCLK_PWR2_DIV_EN
    bus.div_mode = 1'b0;
`endif
    ex_resetn = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    ex_resetn = 1'b1;
    tick();

    // read-back with the internal clock off: bit1 and bits 5:3 read 0
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      write_reg(v);
      check("readback", 32'(bus.clk_ctrl_out), 32'(v & 16'hFFC4));
    end
    write_reg(16'h0000);

    // stable timing
    write_reg(16'h0001);
    c = 0;
    while (bus.clk_ctrl_out[1] !== 1'b1 && c < 100) begin tick(); c++; end
    check("stable_cycles", 32'(c), 32'(STABLE_CYCLES));
    write_reg(16'h0000);
    check("stable_clear", 32'(bus.clk_ctrl_out[1]), 32'd0);

    // divide by 2N with N=4
    write_reg(16'h0401);
    wait_stable();
    write_reg(16'h0405);
    c = 0;
    while (bus.sd_clk !== 1'b1 && c < 100) begin tick(); c++; end
    check("first_rise_delay", 32'(c), 32'd5);
    check("running_on", 32'(bus.sd_clk_running), 32'd1);
    r0 = n_rise;
    f0 = n_fall;
    for (int i = 0; i < 3; i++) measure(4, "div4");
    check("rise_count", 32'(n_rise - r0), 32'd3);
    check("fall_count", 32'(n_fall - f0), 32'd3);

    // glitch-free stop: bit2 cleared one cycle after a rise
    hi = 1;
    write_reg(16'h0401);
    while (bus.sd_clk === 1'b1 && hi < 100) begin hi++; tick(); end
    check("stop_high_len", 32'(hi), 32'd4);
    check("stop_fall", 32'(bus.sd_clk_fall), 32'd1);
    check("stop_running_fall", 32'(bus.sd_clk_running), 32'd1);
    tick();
    check("stop_running_off", 32'(bus.sd_clk_running), 32'd0);
    repeat (8) tick();
    check("stop_sdclk_low", 32'(bus.sd_clk), 32'd0);

    // divisor change mid high phase: 4 -> 1
    write_reg(16'h0405);
    wait_rise(100);
    hi = 1;
    write_reg(16'h0105);
    while (bus.sd_clk === 1'b1 && hi < 100) begin hi++; tick(); end
    check("chg_high_len", 32'(hi), 32'd4);
    lo = 0;
    while (bus.sd_clk === 1'b0 && lo < 100) begin lo++; tick(); end
    check("chg_low_len", 32'(lo), 32'd1);
    measure(1, "div1");

    // wide divisor via bits 7:6, then N=0
    write_reg(16'h0045);
    wait_rise(600);
    measure(256, "div256");
    write_reg(16'h0005);
    wait_rise(600);
    measure(1, "div0");

    // randomized divisors: half-period is max(N,1)
    for (int i = 0; i < 5; i++) begin
      n = $urandom_range(0, 9);
      write_reg({8'(n), 8'h05});
      wait_rise(100);
      measure((n == 0) ? 1 : n, "rand");
    end

`ifdef SDCLK_PWR2_DIV_EN
    bus.div_mode = 1'b1;
    write_reg(16'h0505);
    check("pwr2_readback", 32'(bus.clk_ctrl_out[15:8]), 32'h04);
    wait_rise(100);
    measure(4, "pwr2");
    bus.div_mode = 1'b0;
`endif

    // internal clock disabled during a high phase
    write_reg(16'h0405);
    wait_rise(100);
    hi = 1;
    write_reg(16'h0404);
    check("en_clear_stable", 32'(bus.clk_ctrl_out[1]), 32'd0);
    while (bus.sd_clk === 1'b1 && hi < 100) begin hi++; tick(); end
    check("en_clear_high_len", 32'(hi), 32'd4);
    tick();
    check("en_clear_running", 32'(bus.sd_clk_running), 32'd0);

    // asynchronous reset while sd_clk is high
    write_reg(16'h0401);
    wait_stable();
    write_reg(16'h0405);
    wait_rise(100);
    tick();
    check("pre_reset_high", 32'(bus.sd_clk), 32'd1);
    #2;
    ex_resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sd_clk_gen.md
Name: sd_clk_gen

Overview:
- Programmable SD card clock generator; parametrised successor to the single-bit internal-clock gate in the datapath.
- Owns the 16-bit Clock Control register:
  - internal clock enable
  - internal clock stable
  - SD clock enable
  - divisor, up to 10 bits
- Produces a glitch-free divided card clock plus edge strobes for the command/data shifters.
- Sits between the host register interface and the SD bus logic in the datapath.

Parameters:
- DIV_WIDTH, 10, divisor width. 10 uses {clk_ctrl[7:6], clk_ctrl[15:8]}; 8 uses clk_ctrl[15:8] only, with bits 7:6 read back 0.
- STABLE_CYCLES, 16, ex_clk cycles from internal clock enable until the stable flag sets; legal range 1..255.

Ports:
- ex_clk, input, 1, system/base clock.
- ex_resetn, input, 1, asynchronous active-low reset.
- clk_ctrl_in, input, 16, write data for the Clock Control register.
- clk_ctrl_wr, input, 1, one-cycle write strobe.
- clk_ctrl_out, output, 16, register read-back; bit1 is the live stable flag.
- sd_clk, output, 1, divided card clock, registered.
- sd_clk_rise, output, 1, one-cycle pulse in the first ex_clk cycle that sd_clk is 1.
- sd_clk_fall, output, 1, one-cycle pulse in the first ex_clk cycle that sd_clk is 0 after being 1.
- sd_clk_running, output, 1, high while the divider is active (RUN state).

Behaviour:
- Reset (async, ex_resetn=0): register = 0x0000; all outputs 0; divider counter = 0; stable counter = 0; FSM = OFF.
- Register write (clk_ctrl_wr=1) at the next edge:
  - bits 0, 2 and the divisor field are stored.
  - bit1 is read-only; written value ignored.
  - bits 5:3 read back 0.
- Divisor N = divisor field.
  - N=0: sd_clk toggles every ex_clk cycle (base/2).
  - N>0: sd_clk toggles every N cycles; period = 2N cycles, duty 50%.
  - Divider counter width = DIV_WIDTH; counts 0..N-1, wraps to 0 on toggle.
- Stable counter:
  - bit0=0: counter cleared and stable=0 in the same cycle bit0 is seen low.
  - bit0=1: counter increments each cycle; stable sets when the count reaches STABLE_CYCLES.
  - stable is sticky until bit0 cleared.
- FSM states and transitions:
  - OFF: sd_clk=0, counter held 0. Goes to RUN when bit2=1 and stable=1.
  - RUN: divider active; sd_clk_running=1.
    - At each toggle point, the current divisor field is latched as the next N. A divisor write mid-run therefore takes effect at the next toggle, and no runt pulse is produced.
    - Goes to STOPPING when bit2=0 or stable=0.
  - STOPPING: sd_clk_running=1.
    - If sd_clk=0: go to OFF the next cycle.
    - If sd_clk=1: finish the high phase at the normal toggle point (sd_clk_fall pulses), then go to OFF.
- First edge after RUN entry: counter starts at 0; first rise occurs N cycles after entry (1 cycle if N=0).
- Simultaneous events:
  - bit0 cleared while high phase in progress: stable clears at once; the STOPPING rule still completes the high phase. sd_clk is never truncated high.
  - bit2 re-set while STOPPING: the stop completes to OFF first, then RUN re-enters on the next cycle.
- sd_clk_rise/sd_clk_fall: never both high; both 0 outside RUN/STOPPING.

Optional Feature:
- Macro: SDCLK_PWR2_DIV_EN.
- Defined:
  - Adds input div_mode (1 bit), placed after clk_ctrl_wr.
  - div_mode=1 (SD v2 mode): only bits 15:8 used; effective N = highest set bit of the field (e.g. 0x05 -> 4, 0x00 -> 0).
  - div_mode=1 read-back: clk_ctrl_out[15:8] shows the rounded one-hot value.
  - div_mode=0: linear behaviour as above.
- Not defined: no div_mode port; divisor always linear.

Test Plan:
- Reset value: assert ex_resetn low mid-RUN with sd_clk=1 -> sd_clk, strobes, running and clk_ctrl_out go 0 immediately, without waiting for an edge.
- Stable timing: write 0x0001 -> clk_ctrl_out[1] rises exactly STABLE_CYCLES (16) cycles later. Write 0x0000 -> bit1 clears the next cycle.
- Divide by 2N: write 0x0401 (N=4), wait for stable, write 0x0405 -> first sd_clk rise 4 cycles after RUN entry; period 8 cycles; one rise and one fall strobe per period.
- Glitch-free stop: with N=4, clear bit2 one cycle after a rise -> sd_clk stays high the full 4 cycles, falls with sd_clk_fall, then sd_clk_running=0 and sd_clk stays 0.
- Divisor change mid-run: N=4 running; write N=1 mid-high-phase -> current phase lasts 4 cycles; subsequent phases last 1 cycle.
- N=0 and DIV_WIDTH=10: write 0x0045 (bits 7:6=01, N=256) -> half-period 256 cycles. Write 0x0005 -> sd_clk toggles every cycle.
- SDCLK_PWR2_DIV_EN build: div_mode=1, field 0x05 -> half-period 4 cycles; read-back 0x04.
